// File: rtl/skid_buf_pkg.sv
// skid_buf_pkg: shared state encoding and small helpers for the skid buffer.
// Optional feature macro used by the skid_buf slice: SKID_BUF_STATS_EN.
package skid_buf_pkg;

    // Raw encodings, also usable by a scoreboard that wants to name states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // EMPTY: nothing held, BUSY: main register held, FULL: main and skid held
    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        BUSY  = ST_BUSY,
        FULL  = ST_FULL
    } skid_state_e;

    // Downstream sees valid data whenever the main register is occupied
    function automatic logic holds_main(input skid_state_e st);
        return st != EMPTY;
    endfunction

    // Upstream may push as long as the skid register is still free
    function automatic logic can_accept(input skid_state_e st);
        return st != FULL;
    endfunction

endpackage

// File: rtl/skid_buf_sat_counter.sv
// sat_counter: W-bit saturating event counter with synchronous clear.
// Used by skid_buf to count stall cycles when SKID_BUF_STATS_EN is defined.
module sat_counter
    import skid_buf_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/skid_buf.sv
// skid_buf: two-entry valid/ready register slice with registered s_ready and m_valid.
// Define SKID_BUF_STATS_EN to add the stat_clr input and the stall_cnt output.
module skid_buf
    import skid_buf_pkg::*;
#(
    parameter int DW = 24,
`ifdef SKID_BUF_STATS_EN
    parameter int CNT_W = 16,
`endif
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
`ifdef SKID_BUF_STATS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [DW-1:0]    m_data
);

    skid_state_e   state;
    skid_state_e   state_nxt;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_fire;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;

    // s_ready is low for the first cycle after reset, so it must gate acceptance
    assign in_fire = s_valid && s_ready;

    // Decode next occupancy and which data register loads from both handshakes
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && m_ready) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (m_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (m_ready) begin
                    main_from_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State plus both handshake flags, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            m_valid <= holds_main(state_nxt);
            s_ready <= can_accept(state_nxt);
        end
    end

    // Main register feeds m_data directly and keeps its value when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= RST_VAL;
        end else if (load_main) begin
            main_q <= s_data;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid register catches the word that arrives while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= RST_VAL;
        end else if (load_skid) begin
            skid_q <= s_data;
        end
    end

    assign m_data = main_q;

`ifdef SKID_BUF_STATS_EN
    logic stall;

    assign stall = m_valid && !m_ready;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (stall),
        .cnt   (stall_cnt)
    );
`endif

endmodule
